// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared types for the writeback stage (result source, load size,
//            W-slot state and a reference slot record).
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OFF_W  = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_LINK = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_FULL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'b00,
    ST_FULL      = 2'b01,
    ST_WAIT_MEM  = 2'b10,
    ST_LOAD_DONE = 2'b11
  } wb_state_e;

  typedef struct packed {
    logic              reg_write;
    logic [REG_AW-1:0] reg_dst;
    result_src_e       result_src;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] link;
    mem_size_e         mem_size;
    logic              mem_unsigned;
    logic [OFF_W-1:0]  addr_lo;
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Combinational lane extraction and sign/zero extension of loads.
// Revision : 1.0  initial release
// ============================================================================
module load_extend
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  mem_size_e         size,
  input  logic              is_unsigned,
  input  logic [OFF_W-1:0]  offset,
  output logic [DATA_W-1:0] result
);

  // Misaligned low offset bits are dropped by masking before the lane shift.
  logic [OFF_W-1:0] w_half_off;
  logic [OFF_W-1:0] w_word_off;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_word;
  logic [DATA_W-1:0] w_word_ext;

  assign w_half_off = offset & ~OFF_W'(1);
  assign w_word_off = offset & ~OFF_W'(3);
  assign w_byte     = 8'(data >> {offset, 3'b000});
  assign w_half     = 16'(data >> {w_half_off, 3'b000});
  assign w_word     = 32'(data >> {w_word_off, 3'b000});
  assign w_word_ext = is_unsigned ? DATA_W'(w_word) : DATA_W'($signed(w_word));

  always_comb begin
    result = data;
    case (size)
      SZ_BYTE: result = is_unsigned ? DATA_W'(w_byte) : DATA_W'($signed(w_byte));
      SZ_HALF: result = is_unsigned ? DATA_W'(w_half) : DATA_W'($signed(w_half));
      SZ_WORD: result = w_word_ext;
      default: result = (DATA_W == 32) ? w_word_ext : data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : writeback_ctrl
// Purpose  : W-stage slot that waits for load data, selects the result and
//            drives the register-file write port. WB_LOAD_EXT_EN enables
//            byte/half/word load extraction; otherwise loads pass unmodified.
// Revision : 1.0  initial release
// ============================================================================
module writeback_ctrl
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int REG_AW = 5,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_m_i,
  output logic              ready_w_o,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] reg_dst_m_i,
  input  logic [1:0]        result_src_m_i,
  input  logic [DATA_W-1:0] alu_out_m_i,
  input  logic [DATA_W-1:0] link_m_i,
  input  logic [1:0]        mem_size_m_i,
  input  logic              mem_unsigned_m_i,
  input  logic [OFF_W-1:0]  addr_lo_m_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              valid_w_o,
  output logic              reg_write_w_o,
  output logic [REG_AW-1:0] reg_dst_w_o,
  output logic [DATA_W-1:0] result_w_o
);

  wb_state_e         r_state;
  wb_state_e         w_next_state;
  logic              r_out_of_reset;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_reg_dst;
  result_src_e       r_src;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_link;
  logic [DATA_W-1:0] r_load;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_result;
  logic              w_ready;
  logic              w_valid;
  logic              w_capture;

  // ready stays low until the first edge after reset release.
  assign w_ready   = r_out_of_reset && (r_state != ST_WAIT_MEM);
  assign w_capture = valid_m_i && w_ready;
  assign w_valid   = (r_state == ST_FULL) || (r_state == ST_LOAD_DONE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state        <= ST_EMPTY;
      r_out_of_reset <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_out_of_reset <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT_MEM: if (mem_rvalid_i) w_next_state = ST_LOAD_DONE;
      default: begin
        if (w_capture)
          w_next_state = (result_src_m_i == RES_MEM) ? ST_WAIT_MEM : ST_FULL;
        else
          w_next_state = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_reg_write <= 1'b0;
      r_reg_dst   <= '0;
      r_src       <= RES_ALU;
      r_alu       <= '0;
      r_link      <= '0;
      r_load      <= '0;
    end else begin
      if (w_capture) begin
        r_reg_write <= reg_write_m_i;
        r_reg_dst   <= reg_dst_m_i;
        r_src       <= result_src_e'(result_src_m_i);
        r_alu       <= alu_out_m_i;
        r_link      <= link_m_i;
      end
      if ((r_state == ST_WAIT_MEM) && mem_rvalid_i)
        r_load <= mem_rdata_i;
    end
  end

`ifdef WB_LOAD_EXT_EN
  mem_size_e        r_size;
  logic             r_uns;
  logic [OFF_W-1:0] r_addr_lo;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_size    <= SZ_BYTE;
      r_uns     <= 1'b0;
      r_addr_lo <= '0;
    end else if (w_capture) begin
      r_size    <= mem_size_e'(mem_size_m_i);
      r_uns     <= mem_unsigned_m_i;
      r_addr_lo <= addr_lo_m_i;
    end
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .data        (r_load),
    .size        (r_size),
    .is_unsigned (r_uns),
    .offset      (r_addr_lo),
    .result      (w_load_val)
  );
`else
  logic w_unused_ext;
  assign w_unused_ext = ^{mem_size_m_i, mem_unsigned_m_i, addr_lo_m_i};
  assign w_load_val   = r_load;
`endif

  always_comb begin
    w_result = r_alu;
    case (r_src)
      RES_MEM:  w_result = w_load_val;
      RES_LINK: w_result = r_link;
      default:  w_result = r_alu;
    endcase
    ready_w_o     = w_ready;
    valid_w_o     = w_valid;
    reg_write_w_o = w_valid && r_reg_write && (r_reg_dst != '0);
    reg_dst_w_o   = w_valid ? r_reg_dst : '0;
    result_w_o    = w_valid ? w_result : '0;
  end

endmodule
`default_nettype wire
